// File: rtl/fc_layer_mac_if.sv
// Handshake and bus bundle for fc_layer_mac: start pulse, activation stream,
// weight ROM port and result vector. slave = the MAC block, master = its driver.
// Ports carried: start, in_valid/in_ready/in_data, w_addr/w_data, out_vec/out_valid/done.
interface fc_layer_mac_if #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [7:0]                w_addr;
  logic [N_OUT*DATA_W-1:0]   w_data;
  logic [N_OUT*DATA_W-1:0]   out_vec;
  logic                      out_valid;
  logic                      done;

  modport slave (
    input  start, in_valid, in_data, w_data,
    output in_ready, w_addr, out_vec, out_valid, done
  );

  modport master (
    output start, in_valid, in_data, w_data,
    input  in_ready, w_addr, out_vec, out_valid, done
  );
endinterface

// File: rtl/fc_layer_mac.sv
// Fully-connected layer MAC: N_IN activations x N_OUT weights per row, shift by FRAC, saturate.
// Latency: done 3 cycles after the last transfer (4 when FC_BIAS_EN adds the bias row at N_IN).
// Backpressure: in_ready high only in RUN while inputs remain; in_valid gaps simply stall.
// Ports: clk, reset (sync, active-high), bus (fc_layer_mac_if.slave): start, in_valid/in_ready/in_data,
//        w_addr/w_data (ROM row, data one cycle after address), out_vec/out_valid/done.
// Optional feature macro: FC_BIAS_EN.
module fc_layer_mac #(
  parameter int N_IN   = 84,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic           clk,
  input  logic           reset,
  fc_layer_mac_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, FINAL, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q;
  logic signed [DATA_W-1:0]  act_q;
  logic                      prod_vld_q;
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic [N_OUT*DATA_W-1:0]   out_vec_q;
  logic                      out_valid_q;
  logic                      done_q;

  logic                      in_ready;
  logic                      xfer;
  logic                      start_ok;

  logic signed [ACC_W-1:0]   prod_ext [N_OUT];
  logic signed [ACC_W-1:0]   bias_ext [N_OUT];
  logic [DATA_W-1:0]         sat_val  [N_OUT];

  always_comb begin
    in_ready = (state_q == RUN) && (cnt_q < 8'(N_IN));
    xfer     = in_ready && bus.in_valid;
    start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = RUN;
      RUN:        if (xfer && (cnt_q == 8'(N_IN - 1))) state_d = DRAIN;
      DRAIN: begin
`ifdef FC_BIAS_EN
        state_d = BIAS;
`else
        state_d = FINAL;
`endif
      end
      BIAS:       state_d = FINAL;
      FINAL:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Per-neuron arithmetic. w_data always reflects the row addressed in the
  // previous cycle, so it pairs with act_q (registered on that same transfer).
  for (genvar k = 0; k < N_OUT; k++) begin : g_neuron
    logic signed [DATA_W-1:0]   w_k;
    logic signed [2*DATA_W-1:0] prod_k;
    logic signed [ACC_W-1:0]    shr_k;

    assign w_k    = bus.w_data[k*DATA_W +: DATA_W];
    assign prod_k = $signed({{DATA_W{act_q[DATA_W-1]}}, act_q}) *
                    $signed({{DATA_W{w_k[DATA_W-1]}}, w_k});
    assign prod_ext[k] = {{(ACC_W-2*DATA_W){prod_k[2*DATA_W-1]}}, prod_k};
    // Bias word is in DATA_W fixed point; align it to the accumulator's 2*FRAC scale.
    assign bias_ext[k] = {{(ACC_W-DATA_W-FRAC){w_k[DATA_W-1]}}, w_k, {FRAC{1'b0}}};
    // Arithmetic shift floors toward minus infinity.
    assign shr_k  = acc_q[k] >>> FRAC;
    assign sat_val[k] = (shr_k > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                        (shr_k < SAT_MIN) ? SAT_MIN[DATA_W-1:0] :
                                            shr_k[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      act_q       <= '0;
      prod_vld_q  <= 1'b0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else begin
      prod_vld_q <= xfer;
      done_q     <= (state_q == FINAL);
      if (xfer) act_q <= bus.in_data;

      if (start_ok)  cnt_q <= '0;
      else if (xfer) cnt_q <= cnt_q + 8'd1;

      // The product of a transfer lands one cycle later; DRAIN exists only to
      // let the final product land. BIAS is unreachable without FC_BIAS_EN.
      for (int k = 0; k < N_OUT; k++) begin
        if (start_ok)               acc_q[k] <= '0;
        else if (prod_vld_q)        acc_q[k] <= acc_q[k] + prod_ext[k];
        else if (state_q == BIAS)   acc_q[k] <= acc_q[k] + bias_ext[k];
      end

      if (start_ok)                out_valid_q <= 1'b0;
      else if (state_q == FINAL)   out_valid_q <= 1'b1;

      if (state_q == FINAL) begin
        for (int k = 0; k < N_OUT; k++) out_vec_q[k*DATA_W +: DATA_W] <= sat_val[k];
      end
    end
  end

  // The counter doubles as the ROM address. After the last transfer it sits at
  // N_IN, so the bias row is already addressed in DRAIN and its data arrives in
  // BIAS; without FC_BIAS_EN that row's data is never consumed.
  assign bus.in_ready  = in_ready;
  assign bus.w_addr    = cnt_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fc_layer_mac.sv
// Directed bench for fc_layer_mac with N_IN=4, N_OUT=10, DATA_W=16, FRAC=8.
// Models the weight ROM as a registered read; expected outputs are hand-computed constants.
// Ports: drives the master side of fc_layer_mac_if plus clk and reset.
module tb_fc_layer_mac;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 10;
  localparam int DATA_W = 16;

`ifdef FC_BIAS_EN
  localparam int EXP_LAT  = 4;
  localparam int BIAS_ADJ = 16'h0100;
`else
  localparam int EXP_LAT  = 3;
  localparam int BIAS_ADJ = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [N_OUT*DATA_W-1:0] rom_row [0:N_IN];

  fc_layer_mac_if #(.N_OUT(N_OUT), .DATA_W(DATA_W)) bus ();

  fc_layer_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(8), .ACC_W(40)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM read: data is valid the cycle after the address.
  always @(posedge clk)
    bus.w_data <= (bus.w_addr <= 8'(N_IN)) ? rom_row[bus.w_addr[2:0]] : '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: weight k = k*1.0; mode 1: all weights 0x7FFF. Bias row is always -1.0.
  task automatic load_weights(input int mode);
    for (int r = 0; r < N_IN; r++)
      for (int k = 0; k < N_OUT; k++)
        rom_row[r][k*DATA_W +: DATA_W] = (mode == 1) ? 16'h7FFF : 16'(k * 256);
    for (int k = 0; k < N_OUT; k++) rom_row[N_IN][k*DATA_W +: DATA_W] = 16'hFF00;
  endtask

  // Hand-computed results: mode 0 -> k*0x400 (minus 0x100 with bias);
  // mode 1 -> positive saturation; mode 2 -> negative saturation.
  function automatic logic [15:0] exp_out(input int mode, input int k);
    case (mode)
      0:       return 16'(k * 16'h0400 - BIAS_ADJ);
      1:       return 16'h7FFF;
      default: return 16'h8000;
    endcase
  endfunction

  task automatic run_vector(input logic [15:0] act, input bit gaps, input bit mid_start,
                            input int abort_at, input int mode);
    int  nx, xc, waitc, target, lat;
    bit  rdy_late, seen_done;
    nx = 0; xc = 0; waitc = 0; lat = -1; rdy_late = 0; seen_done = 0;
    target = (abort_at > 0) ? abort_at : N_IN;

    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check_val("out_valid_drop", 32'(bus.out_valid), 32'd0);

    while (nx < target && waitc < 100) begin
      bus.in_valid = gaps ? (waitc % 2 == 1) : 1'b1;
      bus.in_data  = act;
      bus.start    = mid_start && (nx == 1);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        nx++;
        xc = cyc;
      end
      @(negedge clk);
      waitc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (nx < target) check_val("xfer_timeout", 32'(nx), 32'(target));

    if (abort_at > 0) begin
      rst = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (bus.done) seen_done = 1;
      end
      rst = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (bus.done) seen_done = 1;
      end
      check_val("abort_no_done", 32'(seen_done), 32'd0);
      check_val("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("abort_in_ready", 32'(bus.in_ready), 32'd0);
      return;
    end

    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) rdy_late = 1;
      if (bus.done) begin
        lat = cyc - xc;
        break;
      end
      @(negedge clk);
    end
    check_val("latency", 32'(lat), 32'(EXP_LAT));
    check_val("in_ready_after_last", 32'(rdy_late), 32'd0);
    check_val("out_valid_at_done", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < N_OUT; k++)
      check_val($sformatf("out_%0d", k), 32'(bus.out_vec[k*DATA_W +: DATA_W]), 32'(exp_out(mode, k)));
    @(negedge clk);
    check_val("done_one_cycle", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    check_val("out_valid_hold", 32'(bus.out_valid), 32'd1);
    check_val("out_9_hold", 32'(bus.out_vec[9*DATA_W +: DATA_W]), 32'(exp_out(mode, 9)));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    load_weights(0);
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_w_addr", 32'(bus.w_addr), 32'd0);
    check_val("rst_out_vec", 32'(bus.out_vec[31:0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Basic vector: four activations of 1.0.
    run_vector(16'h0100, 1'b0, 1'b0, 0, 0);

    // Saturation, positive then negative; start is accepted from DONE each time.
    load_weights(1);
    run_vector(16'h7FFF, 1'b0, 1'b0, 0, 1);
    run_vector(16'h8001, 1'b0, 1'b0, 0, 2);

    // in_valid gaps on alternating cycles.
    load_weights(0);
    run_vector(16'h0100, 1'b1, 1'b0, 0, 0);

    // start pulsed during RUN must be ignored.
    run_vector(16'h0100, 1'b0, 1'b1, 0, 0);

    // Reset after the 2nd transfer, then a clean vector.
    run_vector(16'h0100, 1'b0, 1'b0, 2, 0);
    run_vector(16'h0100, 1'b0, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
